// File: rtl/link_pair_power_sequencer.sv
// -----------------------------------------------------------------------------
// link_pair_power_sequencer
//
// Sequences power onto the two TIA-568B pair groups:
//   pair0 = 1/2-3/6, pair1 = 5/4-7/8.
// Each pair runs detect, a soft-start ramp, a power-good check, steady-on,
// and fault backoff. The sequencer drives the enable and ramp level of each
// pair's OpAmpSEO redirect stages.
//
// Both pairs share one inrush "ramp slot", so only one pair ramps at a time.
// When both pairs ask for the slot in the same cycle, the round-robin pointer
// pair wins and the pointer moves to the other pair.
//
// Ports
//   Clock100MhzP_i     in   1          single clock, rising edge
//   Reset_i            in   1          synchronous, active-high
//   LinkEnable_i       in   1          global power request; low forces pairs off
//   PairDetectOk_i     in   2          detect comparator per pair ([0]=1236, [1]=5478)
//   PairOverCurrent_i  in   2          overcurrent flag per pair
//   PairPowerGood_i    in   2          output-voltage-good per pair
//   PairDriveEn_o      out  2          enable to the pair's OpAmpSEO stages
//   PairRampLevel_o    out  2*RAMP_W   ramp level; [RAMP_W-1:0] = pair0
//   PairState_o        out  6          3-bit state code per pair; [2:0] = pair0
//   RampBusy_o         out  1          ramp slot held by some pair
//
// Build option
//   LINK_POWER_FAULT_LATCH_EN
//     defined   : after backoff a faulted pair stays in FAULT (outputs 0) until
//                 LinkEnable_i is sampled low, then goes to OFF.
//     undefined : a faulted pair returns to OFF after BACKOFF_CYCLES.
//
// State | meaning
// ------+---------------------------------------------------------------
// OFF   | 0  pair unpowered, waiting for LinkEnable_i
// DETECT| 1  counting consecutive PairDetectOk_i cycles
// WAIT  | 2  detect passed, requesting the shared ramp slot
// RAMP  | 3  holds the slot, soft-start level rising, then power-good wait
// ON    | 4  full scale, monitoring PairPowerGood_i
// FAULT | 5  outputs off, backoff timer running
// -----------------------------------------------------------------------------
module link_pair_power_sequencer #(
   parameter int DETECT_CYCLES    = 64,
   parameter int RAMP_W           = 8,
   parameter int RAMP_STEP_CYCLES = 4,
   parameter int PGOOD_TIMEOUT    = 1024,
   parameter int BACKOFF_CYCLES   = 4096
) (
   input  logic                  Clock100MhzP_i,
   input  logic                  Reset_i,
   input  logic                  LinkEnable_i,
   input  logic [1:0]            PairDetectOk_i,
   input  logic [1:0]            PairOverCurrent_i,
   input  logic [1:0]            PairPowerGood_i,
   output logic [1:0]            PairDriveEn_o,
   output logic [2*RAMP_W-1:0]   PairRampLevel_o,
   output logic [5:0]            PairState_o,
   output logic                  RampBusy_o
);

   typedef enum logic [2:0] {
      ST_OFF       = 3'd0,
      ST_DETECT    = 3'd1,
      ST_WAIT_SLOT = 3'd2,
      ST_RAMP      = 3'd3,
      ST_ON        = 3'd4,
      ST_FAULT     = 3'd5
   } pair_state_e;

   // One down-counter per pair is shared by detect, ramp step, power-good
   // timeout and backoff; it is sized for the longest of them.
   localparam int TMR_MAX_A = (DETECT_CYCLES > RAMP_STEP_CYCLES) ? DETECT_CYCLES : RAMP_STEP_CYCLES;
   localparam int TMR_MAX_B = (PGOOD_TIMEOUT > BACKOFF_CYCLES) ? PGOOD_TIMEOUT : BACKOFF_CYCLES;
   localparam int TMR_MAX   = (TMR_MAX_A > TMR_MAX_B) ? TMR_MAX_A : TMR_MAX_B;
   localparam int TMR_W     = $clog2(TMR_MAX + 1);

   localparam logic [TMR_W-1:0]  TMR_DETECT  = TMR_W'(DETECT_CYCLES - 1);
   localparam logic [TMR_W-1:0]  TMR_STEP    = TMR_W'(RAMP_STEP_CYCLES - 1);
   localparam logic [TMR_W-1:0]  TMR_PGOOD   = TMR_W'(PGOOD_TIMEOUT - 1);
   localparam logic [TMR_W-1:0]  TMR_BACKOFF = TMR_W'(BACKOFF_CYCLES - 1);
   localparam logic [RAMP_W-1:0] LVL_FULL    = '1;
   localparam logic [RAMP_W-1:0] LVL_PRE     = LVL_FULL - RAMP_W'(1);

   pair_state_e       state_q [2];
   pair_state_e       state_d [2];
   logic [TMR_W-1:0]  tmr_q   [2];
   logic [TMR_W-1:0]  tmr_d   [2];
   logic [RAMP_W-1:0] level_q [2];
   logic [RAMP_W-1:0] level_d [2];
   logic [1:0]        drive_q;
   logic [1:0]        drive_d;
   logic              busy_q;
   logic              ptr_q;
   logic              ptr_d;
   logic [1:0]        req;
   logic [1:0]        grant;

   // Slot arbitration. busy_q reflects the states currently registered, so a
   // pair leaving RAMP frees the slot for a grant one cycle later.
   always_comb begin
      req   = '0;
      grant = '0;
      ptr_d = ptr_q;
      for (int p = 0; p < 2; p++) begin
         req[p] = (state_q[p] == ST_WAIT_SLOT) && LinkEnable_i;
      end
      if (!busy_q) begin
         if (req == 2'b11) begin
            grant[ptr_q] = 1'b1;
            ptr_d        = ~ptr_q;
         end else begin
            grant = req;
         end
      end
   end

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         state_d[p] = state_q[p];
         tmr_d[p]   = tmr_q[p];
         level_d[p] = level_q[p];
         drive_d[p] = drive_q[p];

         if (((state_q[p] == ST_RAMP) || (state_q[p] == ST_ON)) && PairOverCurrent_i[p]) begin
            state_d[p] = ST_FAULT;
            tmr_d[p]   = TMR_BACKOFF;
            level_d[p] = '0;
            drive_d[p] = 1'b0;
         end else if (!LinkEnable_i && (state_q[p] != ST_FAULT) && (state_q[p] != ST_OFF)) begin
            // FAULT is exempt: it always finishes its backoff.
            state_d[p] = ST_OFF;
            tmr_d[p]   = '0;
            level_d[p] = '0;
            drive_d[p] = 1'b0;
         end else begin
            case (state_q[p])
               ST_OFF: begin
                  level_d[p] = '0;
                  drive_d[p] = 1'b0;
                  if (LinkEnable_i) begin
                     state_d[p] = ST_DETECT;
                     tmr_d[p]   = TMR_DETECT;
                  end
               end
               ST_DETECT: begin
                  if (!PairDetectOk_i[p]) begin
                     tmr_d[p] = TMR_DETECT;
                  end else if (tmr_q[p] == '0) begin
                     state_d[p] = ST_WAIT_SLOT;
                  end else begin
                     tmr_d[p] = tmr_q[p] - 1'b1;
                  end
               end
               ST_WAIT_SLOT: begin
                  if (grant[p]) begin
                     state_d[p] = ST_RAMP;
                     tmr_d[p]   = TMR_STEP;
                     level_d[p] = '0;
                     drive_d[p] = 1'b1;
                  end
               end
               ST_RAMP: begin
                  if (level_q[p] == LVL_FULL) begin
                     // Power-good only counts once the ramp is at full scale.
                     if (PairPowerGood_i[p]) begin
                        state_d[p] = ST_ON;
                     end else if (tmr_q[p] == '0) begin
                        state_d[p] = ST_FAULT;
                        tmr_d[p]   = TMR_BACKOFF;
                        level_d[p] = '0;
                        drive_d[p] = 1'b0;
                     end else begin
                        tmr_d[p] = tmr_q[p] - 1'b1;
                     end
                  end else if (tmr_q[p] == '0) begin
                     level_d[p] = level_q[p] + 1'b1;
                     // Reaching full scale arms the power-good timeout.
                     tmr_d[p]   = (level_q[p] == LVL_PRE) ? TMR_PGOOD : TMR_STEP;
                  end else begin
                     tmr_d[p] = tmr_q[p] - 1'b1;
                  end
               end
               ST_ON: begin
                  level_d[p] = LVL_FULL;
                  drive_d[p] = 1'b1;
                  if (!PairPowerGood_i[p]) begin
                     state_d[p] = ST_FAULT;
                     tmr_d[p]   = TMR_BACKOFF;
                     level_d[p] = '0;
                     drive_d[p] = 1'b0;
                  end
               end
               ST_FAULT: begin
                  level_d[p] = '0;
                  drive_d[p] = 1'b0;
                  if (tmr_q[p] != '0) begin
                     tmr_d[p] = tmr_q[p] - 1'b1;
`ifdef LINK_POWER_FAULT_LATCH_EN
                  end else if (!LinkEnable_i) begin
                     state_d[p] = ST_OFF;
`else
                  end else begin
                     state_d[p] = ST_OFF;
`endif
                  end
               end
               default: begin
                  state_d[p] = ST_OFF;
                  tmr_d[p]   = '0;
                  level_d[p] = '0;
                  drive_d[p] = 1'b0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge Clock100MhzP_i) begin
      if (Reset_i) begin
         for (int p = 0; p < 2; p++) begin
            state_q[p] <= ST_OFF;
            tmr_q[p]   <= '0;
            level_q[p] <= '0;
         end
         drive_q <= '0;
         busy_q  <= 1'b0;
         ptr_q   <= 1'b0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            state_q[p] <= state_d[p];
            tmr_q[p]   <= tmr_d[p];
            level_q[p] <= level_d[p];
         end
         drive_q <= drive_d;
         busy_q  <= (state_d[0] == ST_RAMP) || (state_d[1] == ST_RAMP);
         ptr_q   <= ptr_d;
      end
   end

   assign PairDriveEn_o   = drive_q;
   assign PairRampLevel_o = {level_q[1], level_q[0]};
   assign PairState_o     = {state_q[1], state_q[0]};
   assign RampBusy_o      = busy_q;

endmodule

// File: tb/tb_link_pair_power_sequencer.sv
// -----------------------------------------------------------------------------
// tb_link_pair_power_sequencer
//
// Directed bench for link_pair_power_sequencer with small timing parameters.
// Inputs are applied between edges; outputs are sampled 1 time unit after the
// rising edge, so "edge N" below means the state after the Nth edge that
// followed reset release with the given inputs.
// -----------------------------------------------------------------------------
module tb_link_pair_power_sequencer;

   localparam int DETECT_CYCLES    = 4;
   localparam int RAMP_W           = 3;
   localparam int RAMP_STEP_CYCLES = 2;
   localparam int PGOOD_TIMEOUT    = 8;
   localparam int BACKOFF_CYCLES   = 16;

   localparam int S_OFF    = 0;
   localparam int S_DETECT = 1;
   localparam int S_WAIT   = 2;
   localparam int S_RAMP   = 3;
   localparam int S_ON     = 4;
   localparam int S_FAULT  = 5;

   logic                clk = 1'b0;
   logic                reset;
   logic                link_en;
   logic [1:0]          det_ok;
   logic [1:0]          oc;
   logic [1:0]          pgood;
   logic [1:0]          drive_en;
   logic [2*RAMP_W-1:0] ramp_level;
   logic [5:0]          pair_state;
   logic                ramp_busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   link_pair_power_sequencer #(
      .DETECT_CYCLES   (DETECT_CYCLES),
      .RAMP_W          (RAMP_W),
      .RAMP_STEP_CYCLES(RAMP_STEP_CYCLES),
      .PGOOD_TIMEOUT   (PGOOD_TIMEOUT),
      .BACKOFF_CYCLES  (BACKOFF_CYCLES)
   ) dut (
      .Clock100MhzP_i   (clk),
      .Reset_i          (reset),
      .LinkEnable_i     (link_en),
      .PairDetectOk_i   (det_ok),
      .PairOverCurrent_i(oc),
      .PairPowerGood_i  (pgood),
      .PairDriveEn_o    (drive_en),
      .PairRampLevel_o  (ramp_level),
      .PairState_o      (pair_state),
      .RampBusy_o       (ramp_busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic expect_pair(input string tag, input int p, input int st, input int drv, input int lvl);
      logic [2:0]        s;
      logic [RAMP_W-1:0] l;
      s = (p == 0) ? pair_state[2:0] : pair_state[5:3];
      l = (p == 0) ? ramp_level[RAMP_W-1:0] : ramp_level[2*RAMP_W-1:RAMP_W];
      check_eq({tag, ".state"}, 32'(s), 32'(st));
      check_eq({tag, ".drive"}, 32'(drive_en[p]), 32'(drv));
      check_eq({tag, ".level"}, 32'(l), 32'(lvl));
   endtask

   task automatic expect_all_zero(input string tag);
      check_eq({tag, ".state"}, 32'(pair_state), 32'd0);
      check_eq({tag, ".drive"}, 32'(drive_en), 32'd0);
      check_eq({tag, ".level"}, 32'(ramp_level), 32'd0);
      check_eq({tag, ".busy"}, 32'(ramp_busy), 32'd0);
   endtask

   task automatic do_reset(input string tag);
      reset   = 1'b1;
      link_en = 1'b0;
      det_ok  = 2'b00;
      oc      = 2'b00;
      pgood   = 2'b00;
      step(2);
      expect_all_zero({tag, ".rst"});
      reset = 1'b0;
   endtask

   initial begin
      reset   = 1'b1;
      link_en = 1'b0;
      det_ok  = 2'b00;
      oc      = 2'b00;
      pgood   = 2'b00;

      // 1: pair0 detect, ramp 0..7, ON; pair1 never detects.
      do_reset("t1");
      link_en = 1'b1; det_ok = 2'b01; pgood = 2'b01;
      for (int e = 1; e <= 21; e++) begin
         tick();
         if (e <= 4) begin
            expect_pair("t1.det", 0, S_DETECT, 0, 0);
         end else if (e == 5) begin
            expect_pair("t1.wait", 0, S_WAIT, 0, 0);
         end else if (e <= 20) begin
            expect_pair("t1.ramp", 0, S_RAMP, 1, (e - 6) / 2);
            check_eq("t1.busy", 32'(ramp_busy), 32'd1);
         end else begin
            expect_pair("t1.on", 0, S_ON, 1, 7);
            check_eq("t1.busy_rel", 32'(ramp_busy), 32'd0);
         end
         expect_pair("t1.p1", 1, S_DETECT, 0, 0);
      end

      // 2: one low detect cycle after three high ones restarts the count.
      do_reset("t2");
      link_en = 1'b1; pgood = 2'b00;
      for (int e = 1; e <= 10; e++) begin
         det_ok = (e == 5) ? 2'b00 : 2'b01;
         tick();
         if (e <= 8)       expect_pair("t2.det", 0, S_DETECT, 0, 0);
         else if (e == 9)  expect_pair("t2.wait", 0, S_WAIT, 0, 0);
         else              expect_pair("t2.ramp", 0, S_RAMP, 1, 0);
      end

      // 3: simultaneous requests, round-robin both ways.
      do_reset("t3");
      link_en = 1'b1; det_ok = 2'b11; pgood = 2'b11;
      step(5);
      expect_pair("t3.w0", 0, S_WAIT, 0, 0);
      expect_pair("t3.w1", 1, S_WAIT, 0, 0);
      tick();
      expect_pair("t3.g0", 0, S_RAMP, 1, 0);
      expect_pair("t3.hold1", 1, S_WAIT, 0, 0);
      step(14);
      expect_pair("t3.full0", 0, S_RAMP, 1, 7);
      tick();
      expect_pair("t3.on0", 0, S_ON, 1, 7);
      expect_pair("t3.exitwait1", 1, S_WAIT, 0, 0);
      check_eq("t3.busy_gap", 32'(ramp_busy), 32'd0);
      tick();
      expect_pair("t3.g1", 1, S_RAMP, 1, 0);
      check_eq("t3.busy1", 32'(ramp_busy), 32'd1);
      step(15);
      expect_pair("t3.on1", 1, S_ON, 1, 7);
      expect_pair("t3.on0b", 0, S_ON, 1, 7);
      link_en = 1'b0;
      tick();
      expect_pair("t3.off0", 0, S_OFF, 0, 0);
      expect_pair("t3.off1", 1, S_OFF, 0, 0);
      link_en = 1'b1;
      step(5);
      expect_pair("t3.rw0", 0, S_WAIT, 0, 0);
      expect_pair("t3.rw1", 1, S_WAIT, 0, 0);
      tick();
      expect_pair("t3.rg1", 1, S_RAMP, 1, 0);
      expect_pair("t3.rhold0", 0, S_WAIT, 0, 0);
      step(15);
      expect_pair("t3.ron1", 1, S_ON, 1, 7);
      expect_pair("t3.rstill0", 0, S_WAIT, 0, 0);
      tick();
      expect_pair("t3.rg0", 0, S_RAMP, 1, 0);

      // 4: power-good timeout, backoff, retry (or latch).
      do_reset("t4");
      link_en = 1'b1; det_ok = 2'b01; pgood = 2'b00;
      step(20);
      expect_pair("t4.full", 0, S_RAMP, 1, 7);
      step(7);
      expect_pair("t4.last", 0, S_RAMP, 1, 7);
      tick();
      expect_pair("t4.fault", 0, S_FAULT, 0, 0);
      check_eq("t4.busy", 32'(ramp_busy), 32'd0);
      step(15);
      expect_pair("t4.fault_end", 0, S_FAULT, 0, 0);
      tick();
`ifdef LINK_POWER_FAULT_LATCH_EN
      expect_pair("t4.latched", 0, S_FAULT, 0, 0);
      tick();
      expect_pair("t4.latched2", 0, S_FAULT, 0, 0);
      link_en = 1'b0;
      tick();
      expect_pair("t4.unlatch", 0, S_OFF, 0, 0);
`else
      expect_pair("t4.off", 0, S_OFF, 0, 0);
      tick();
      expect_pair("t4.retry", 0, S_DETECT, 0, 0);
`endif

      // 5: overcurrent beats LinkEnable low.
      do_reset("t5");
      link_en = 1'b1; det_ok = 2'b11; pgood = 2'b11;
      step(37);
      expect_pair("t5.on0", 0, S_ON, 1, 7);
      expect_pair("t5.on1", 1, S_ON, 1, 7);
      oc = 2'b10; link_en = 1'b0;
      tick();
      expect_pair("t5.off0", 0, S_OFF, 0, 0);
      expect_pair("t5.fault1", 1, S_FAULT, 0, 0);
      oc = 2'b00;
      step(15);
      expect_pair("t5.backoff1", 1, S_FAULT, 0, 0);
      tick();
      expect_pair("t5.done1", 1, S_OFF, 0, 0);

      // 6: reset mid-ramp clears everything including the pointer.
      do_reset("t6");
      link_en = 1'b1; det_ok = 2'b11; pgood = 2'b11;
      step(12);
      expect_pair("t6.lvl3", 0, S_RAMP, 1, 3);
      expect_pair("t6.wait1", 1, S_WAIT, 0, 0);
      reset = 1'b1;
      tick();
      expect_all_zero("t6.rst");
      reset = 1'b0;
      step(6);
      expect_pair("t6.ptr0", 0, S_RAMP, 1, 0);
      expect_pair("t6.ptr1", 1, S_WAIT, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
